pipe_stage_ctrl: RTL and testbench



---
 rtl/pipe_stage_ctrl_if.sv | 22 ++
 rtl/pipe_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_ctrl_if.sv
// Valid/ready handshake bundle for one pipeline register stage.
// The slave side belongs to the stage controller. The master side is its environment.
interface pipe_stage_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage controller with a main register, a skid register and a valid/ready handshake.
// It also has a flush input for squash and a saturating stall counter for performance monitoring.
module pipe_stage_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   pipe_stage_ctrl_if.slave bus,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [1:0]        occ_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   logic accept;
   logic fire;
   logic stall;
   logic main_we;
   logic main_from_skid;
   logic skid_we;

   // Handshake qualifiers use only registered flags.
   // As a result, in_ready never depends on out_ready in the same cycle.
   assign accept = bus.in_valid && in_ready_q;
   assign fire   = out_valid_q && bus.out_ready;
   assign stall  = out_valid_q && !bus.out_ready;

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
      state_nxt      = state;
      main_we        = 1'b0;
      main_from_skid = 1'b0;
      skid_we        = 1'b0;

      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               main_we   = 1'b1;
            end
         end
         ONE: begin
            if (accept && fire) begin
               main_we = 1'b1;
            end else if (accept) begin
               state_nxt = FULL;
               skid_we   = 1'b1;
            end else if (fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (fire) begin
               state_nxt      = ONE;
               main_we        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase

      // Squash wins over every transition.
      // Any word offered in the same cycle is dropped.
      if (flush) begin
         state_nxt = EMPTY;
         main_we   = 1'b0;
         skid_we   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= 2'd0;
         // NOTE: the data registers are reset as well, because main drives out_data and must read zero after reset.
         main_q      <= '0;
         skid_q      <= '0;
         stall_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample its pre-edge inputs, whatever the statement order.
         state       <= state_nxt;
         in_ready_q  <= (state_nxt != FULL);
         out_valid_q <= (state_nxt != EMPTY);
         occ_q       <= (state_nxt == FULL) ? 2'd2 :
                        (state_nxt == ONE)  ? 2'd1 : 2'd0;
         if (main_we) begin
            main_q <= main_from_skid ? skid_q : bus.in_data;
         end
         if (skid_we) begin
            skid_q <= bus.in_data;
         end
         if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign occupancy     = occ_q;

   // A word held under backpressure must not change until it is taken or squashed.
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready && !flush) |=> (out_valid_q && $stable(main_q)));

   a_ready_matches_occ: assert property (@(posedge clk) disable iff (!rst_n)
      in_ready_q == (occ_q != 2'd2));

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: directed scenarios followed by randomized traffic.
// Accepted words are queued by the driver. The monitor checks each word in FIFO order.
module tb_pipe_stage_ctrl;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;

   pipe_stage_ctrl_if #(.DATA_W(DATA_W)) bus ();

   pipe_stage_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .bus       (bus),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: entries held, words still owed downstream, expected stall count.
   int               model_cnt = 0;
   int               stall_exp = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus. The inputs apply at the next rising edge.
   task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
      @(negedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      flush         = f;
      if (rst_n && v && !f && model_cnt < 2) exp_q.push_back(d);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      flush         = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: samples mid-cycle, after the driver has set the inputs for the next edge.
   always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
         model_cnt = 0;
         stall_exp = 0;
         exp_q.delete();
      end else begin
         check("in_ready", 32'(bus.in_ready), 32'(model_cnt < 2));
         check("out_valid", 32'(bus.out_valid), 32'(model_cnt != 0));
         check("occupancy", 32'(occupancy), 32'(model_cnt));
         check("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
         if (model_cnt != 0) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q[0]);
         end
         if (model_cnt != 0 && !bus.out_ready && stall_exp < CNT_MAX) stall_exp++;
         if (model_cnt != 0 && bus.out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            model_cnt--;
         end
         if (flush) begin
            exp_q.delete();
            model_cnt = 0;
         end else if (bus.in_valid && model_cnt < 2 - ((model_cnt != 0 && bus.out_ready) ? 0 : 0)) begin
            model_cnt = exp_q.size();
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      do_reset();

      // Streaming with out_ready held high.
      cycle(1'b1, 32'h11, 1'b1, 1'b0);
      cycle(1'b1, 32'h22, 1'b1, 1'b0);
      cycle(1'b1, 32'h33, 1'b1, 1'b0);
      cycle(1'b0, 32'h0,  1'b1, 1'b0);
      cycle(1'b0, 32'h0,  1'b1, 1'b0);

      // Backpressure fill, a blocked third word, then drain in order.
      cycle(1'b1, 32'hA0, 1'b0, 1'b0);
      cycle(1'b1, 32'hA1, 1'b0, 1'b0);
      cycle(1'b1, 32'hA2, 1'b0, 1'b0);
      settle();
      check("full_occupancy", 32'(occupancy), 32'd2);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_head", bus.out_data, 32'hA0);
      cycle(1'b1, 32'hA2, 1'b1, 1'b0);
      cycle(1'b1, 32'hA2, 1'b1, 1'b0);
      cycle(1'b0, 32'h0,  1'b1, 1'b0);
      cycle(1'b0, 32'h0,  1'b1, 1'b0);

      // A word is taken and another is accepted in the same cycle while in state ONE.
      cycle(1'b1, 32'h5, 1'b0, 1'b0);
      cycle(1'b1, 32'h6, 1'b1, 1'b0);
      settle();
      check("swap_out_data", bus.out_data, 32'h6);
      check("swap_occupancy", 32'(occupancy), 32'd1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Flush while FULL, with an offered word and a firing output.
      cycle(1'b1, 32'hB0, 1'b0, 1'b0);
      cycle(1'b1, 32'hB1, 1'b0, 1'b0);
      cycle(1'b1, 32'h77, 1'b1, 1'b1);
      settle();
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_occupancy", 32'(occupancy), 32'd0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Stall counter saturation, then retention through flush, then clear by reset.
      do_reset();
      cycle(1'b1, 32'hC0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      settle();
      check("stall_saturated", 32'(stall_cnt), CNT_MAX);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      settle();
      check("stall_after_flush", 32'(stall_cnt), CNT_MAX);
      do_reset();

      // Asynchronous reset while FULL. The checks inside do_reset run before any clock edge.
      cycle(1'b1, 32'hD0, 1'b0, 1'b0);
      cycle(1'b1, 32'hD1, 1'b0, 1'b0);
      settle();
      check("pre_areset_occ", 32'(occupancy), 32'd2);
      do_reset();
      cycle(1'b1, 32'hE0, 1'b1, 1'b0);
      settle();
      check("post_reset_accept", bus.out_data, 32'hE0);

      // Randomized traffic checked by the scoreboard.
      for (int i = 0; i < 1500; i++) begin
         cycle(logic'($urandom_range(0, 9) < 7), $urandom, logic'($urandom_range(0, 9) < 6),
               logic'($urandom_range(0, 49) == 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      settle();
      check("drained", 32'(model_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
